// File: rtl/xadc_drp_package.sv
// Sequencer state type and default DRP channel addresses for the XADC sampler.
package xadc_drp_package;

  localparam logic [6:0] XADC_VOLTAGE_ADDR_DEFAULT = 7'h13;
  localparam logic [6:0] XADC_CURRENT_ADDR_DEFAULT = 7'h1B;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_V  = 3'd1,
    WAIT_V = 3'd2,
    REQ_I  = 3'd3,
    WAIT_I = 3'd4,
    PUSH   = 3'd5
  } xadc_sampler_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/xadc_packet_package.sv
// Packet framing constants shared by XADC sample producers.
package xadc_packet_package;

  localparam logic [7:0] XADC_PACKET_HEADER_LOW_SPEED_SAMPLE = 8'h01;

  // A 12-bit XADC conversion sits in the upper bits of the status register.
  function automatic logic [15:0] pack_low_speed_sample(input logic [15:0] raw);
    return {XADC_PACKET_HEADER_LOW_SPEED_SAMPLE[3:0], raw[15:4]};
  endfunction

endpackage

// File: rtl/axis_interface.sv
// Minimal AXI-Stream bundle with source and sink views.
interface axis_interface #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 1,
  parameter int DEST_W = 1,
  parameter int USER_W = 1
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;
  logic [ID_W-1:0]       tid;
  logic [DEST_W-1:0]     tdest;
  logic [USER_W-1:0]     tuser;

  modport Source (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
  modport Sink   (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/xadc_drp_read.sv
// One DRP read: a single-cycle den strobe followed by a bounded wait for drdy.
module xadc_drp_read #(
  parameter int DRP_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  addr_i,
  input  logic        drdy_i,
  input  logic [15:0] do_data_i,
  output logic        den_o,
  output logic [6:0]  daddr_o,
  output logic        done_o,
  output logic [15:0] data_o,
  output logic        timeout_o
);
  localparam int CNT_W = (DRP_TIMEOUT > 1) ? $clog2(DRP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(DRP_TIMEOUT - 1);

  logic             den_q;
  logic [6:0]       daddr_q;
  logic             wait_q;
  logic [CNT_W-1:0] cnt_q;

  // drdy is only honoured from the cycle after the strobe until the read closes.
  assign done_o    = wait_q & drdy_i;
  assign timeout_o = wait_q & ~drdy_i & (cnt_q == LAST_WAIT);
  assign data_o    = do_data_i;
  assign den_o     = den_q;
  assign daddr_o   = daddr_q;

  // Strobe, then count wait cycles until drdy or the timeout limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      den_q   <= 1'b0;
      daddr_q <= 7'h00;
      wait_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (start_i) begin
      den_q   <= 1'b1;
      daddr_q <= addr_i;
      wait_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (den_q) begin
      den_q  <= 1'b0;
      wait_q <= 1'b1;
      cnt_q  <= '0;
    end else if (wait_q) begin
      if (drdy_i || (cnt_q == LAST_WAIT)) begin
        wait_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      den_q <= 1'b0;
    end
  end

endmodule

// File: rtl/xadc_drp_sampler.sv
// On each XADC end-of-sequence, reads the voltage and current channels over DRP
// and offers both readings as one paired beat on two AXI-Stream sources.
module xadc_drp_sampler
  import xadc_drp_package::*, xadc_packet_package::*;
#(
  parameter logic [6:0] VOLTAGE_ADDR = XADC_VOLTAGE_ADDR_DEFAULT,
  parameter logic [6:0] CURRENT_ADDR = XADC_CURRENT_ADDR_DEFAULT,
  parameter int         DRP_TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          eos,
  output logic [6:0]    daddr,
  output logic          den,
  output logic          dwe,
  output logic [15:0]   di,
  input  logic [15:0]   do_data,
  input  logic          drdy,
  axis_interface.Source voltage_channel,
  axis_interface.Source current_monitor_channel,
  output logic [15:0]   overrun_count,
  output logic          drp_timeout_err
);

  xadc_sampler_state_t state_q;
  logic                v_valid_q;
  logic                i_valid_q;
  logic [15:0]         v_data_q;
  logic [15:0]         i_data_q;
  logic [15:0]         ovr_q;
  logic [15:0]         ovr_d;
  logic                err_q;

  logic                rd_start_s;
  logic [6:0]          rd_addr_s;
  logic                rd_done_s;
  logic [15:0]         rd_data_s;
  logic                rd_timeout_s;
  logic                v_fin_s;
  logic                i_fin_s;

  assign ovr_d   = sat_inc16(ovr_q);
  assign v_fin_s = ~v_valid_q | voltage_channel.tready;
  assign i_fin_s = ~i_valid_q | current_monitor_channel.tready;

  // Kick a read on accepted eos (voltage) and on voltage completion (current).
  always_comb begin
    rd_start_s = 1'b0;
    rd_addr_s  = VOLTAGE_ADDR;
    if ((state_q == IDLE) && eos) begin
      rd_start_s = 1'b1;
      rd_addr_s  = VOLTAGE_ADDR;
    end else if ((state_q == WAIT_V) && rd_done_s) begin
      rd_start_s = 1'b1;
      rd_addr_s  = CURRENT_ADDR;
    end else begin
      rd_start_s = 1'b0;
      rd_addr_s  = VOLTAGE_ADDR;
    end
  end

  xadc_drp_read #(
    .DRP_TIMEOUT (DRP_TIMEOUT)
  ) u_drp_read (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (rd_start_s),
    .addr_i    (rd_addr_s),
    .drdy_i    (drdy),
    .do_data_i (do_data),
    .den_o     (den),
    .daddr_o   (daddr),
    .done_o    (rd_done_s),
    .data_o    (rd_data_s),
    .timeout_o (rd_timeout_s)
  );

  // Sequencer: one read pair per accepted eos, then hold the beat until both sinks take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      v_valid_q <= 1'b0;
      i_valid_q <= 1'b0;
      v_data_q  <= 16'h0000;
      i_data_q  <= 16'h0000;
      ovr_q     <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      if (eos && (state_q != IDLE)) begin
        ovr_q <= ovr_d;
      end
      case (state_q)
        IDLE: begin
          if (eos) state_q <= REQ_V;
        end
        REQ_V: state_q <= WAIT_V;
        WAIT_V: begin
          if (rd_done_s) begin
            v_data_q <= pack_low_speed_sample(rd_data_s);
            state_q  <= REQ_I;
          end else if (rd_timeout_s) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        REQ_I: state_q <= WAIT_I;
        WAIT_I: begin
          if (rd_done_s) begin
            i_data_q  <= pack_low_speed_sample(rd_data_s);
            v_valid_q <= 1'b1;
            i_valid_q <= 1'b1;
            state_q   <= PUSH;
          end else if (rd_timeout_s) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        PUSH: begin
          // Each stream retires on its own handshake; the pair retires when both have.
          if (v_fin_s && i_fin_s) begin
            v_valid_q <= 1'b0;
            i_valid_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            if (v_fin_s) v_valid_q <= 1'b0;
            if (i_fin_s) i_valid_q <= 1'b0;
          end
        end
        default: begin
          v_valid_q <= 1'b0;
          i_valid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign dwe             = 1'b0;
  assign di              = 16'h0000;
  assign overrun_count   = ovr_q;
  assign drp_timeout_err = err_q;

  assign voltage_channel.tvalid = v_valid_q;
  assign voltage_channel.tdata  = v_data_q;
  assign voltage_channel.tlast  = v_valid_q;
  assign voltage_channel.tkeep  = '1;
  assign voltage_channel.tid    = '0;
  assign voltage_channel.tdest  = '0;
  assign voltage_channel.tuser  = '0;

  assign current_monitor_channel.tvalid = i_valid_q;
  assign current_monitor_channel.tdata  = i_data_q;
  assign current_monitor_channel.tlast  = i_valid_q;
  assign current_monitor_channel.tkeep  = '1;
  assign current_monitor_channel.tid    = '0;
  assign current_monitor_channel.tdest  = '0;
  assign current_monitor_channel.tuser  = '0;

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Directed bench for xadc_drp_sampler with a timestamp-based reference model.
module tb_xadc_drp_sampler;

  localparam logic [6:0] VADDR = 7'h13;
  localparam logic [6:0] IADDR = 7'h1B;
  localparam int         TMO   = 255;

  logic        clk;
  logic        rst;
  logic        eos;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] do_data;
  logic        drdy;
  logic [15:0] ovr;
  logic        err;

  axis_interface #(.DATA_W(16)) v_if ();
  axis_interface #(.DATA_W(16)) i_if ();

  xadc_drp_sampler dut (
    .clk                     (clk),
    .rst                     (rst),
    .eos                     (eos),
    .daddr                   (daddr),
    .den                     (den),
    .dwe                     (dwe),
    .di                      (di),
    .do_data                 (do_data),
    .drdy                    (drdy),
    .voltage_channel         (v_if),
    .current_monitor_channel (i_if),
    .overrun_count           (ovr),
    .drp_timeout_err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Responder configuration (lat = cycles from den to drdy, 0 = never answers)
  int          lat   = 1;
  logic [15:0] v_raw = 16'hABC0;
  logic [15:0] i_raw = 16'h1230;

  // Model state: one transaction described by its start cycle and drdy latency
  int          cyc = 0;
  bit          m_ok = 1'b0;
  bit          m_busy = 1'b0;
  int          m_d = 0;
  int          m_lat = 1;
  bit          m_vv = 1'b0;
  bit          m_iv = 1'b0;
  logic [15:0] m_vexp = 16'h0000;
  logic [15:0] m_iexp = 16'h0000;
  logic [15:0] m_ovr = 16'h0000;
  bit          m_err = 1'b0;
  logic [6:0]  m_daddr = 7'h00;
  int          v_hs = 0;
  int          i_hs = 0;

  function automatic logic [15:0] pk(input logic [15:0] r);
    return {4'h1, r[15:4]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // DRP responder: answers each den after lat cycles with the channel's raw value
  initial begin
    int          cd;
    logic [15:0] pend;
    cd = 0;
    pend = 16'h0000;
    drdy = 1'b0;
    do_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (den === 1'b1 && lat != 0) begin
        cd = lat;
        pend = (daddr == VADDR) ? v_raw : i_raw;
      end
      @(posedge clk);
      #1;
      drdy = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          drdy = 1'b1;
          do_data = pend;
        end
      end
    end
  end

  task automatic step();
    bit e_den;
    if (m_ok) begin
      e_den = m_busy && (cyc == m_d || (m_lat != 0 && cyc == m_d + m_lat + 1));
      if (e_den) m_daddr = (cyc == m_d) ? VADDR : IADDR;
      chk("den", {31'd0, den}, {31'd0, e_den});
      chk("daddr", {25'd0, daddr}, {25'd0, m_daddr});
      chk("dwe_di", {15'd0, dwe, di}, 32'd0);
      chk("v_tvalid", {31'd0, v_if.tvalid}, {31'd0, m_vv});
      chk("i_tvalid", {31'd0, i_if.tvalid}, {31'd0, m_iv});
      if (m_vv) begin
        chk("v_tdata", {16'd0, v_if.tdata}, {16'd0, m_vexp});
        chk("v_tlast_tkeep", {29'd0, v_if.tlast, v_if.tkeep}, 32'h7);
      end
      if (m_iv) begin
        chk("i_tdata", {16'd0, i_if.tdata}, {16'd0, m_iexp});
        chk("i_tlast_tkeep", {29'd0, i_if.tlast, i_if.tkeep}, 32'h7);
      end
      chk("side_zero", {26'd0, v_if.tid, v_if.tdest, v_if.tuser, i_if.tid, i_if.tdest, i_if.tuser}, 32'd0);
      chk("overrun", {16'd0, ovr}, {16'd0, m_ovr});
      chk("timeout_err", {31'd0, err}, {31'd0, m_err});
    end
    if (v_if.tvalid === 1'b1 && v_if.tready === 1'b1) v_hs++;
    if (i_if.tvalid === 1'b1 && i_if.tready === 1'b1) i_hs++;
    if (rst) begin
      m_busy = 1'b0; m_vv = 1'b0; m_iv = 1'b0;
      m_ovr = 16'h0000; m_err = 1'b0; m_daddr = 7'h00; m_ok = 1'b1;
    end else if (m_ok) begin
      bit nb;
      nb = m_busy;
      if (m_busy) begin
        if (m_lat == 0 && cyc == m_d + TMO) begin
          m_err = 1'b1;
          nb = 1'b0;
        end else if (m_vv || m_iv) begin
          if (m_vv && v_if.tready) m_vv = 1'b0;
          if (m_iv && i_if.tready) m_iv = 1'b0;
          if (!m_vv && !m_iv) nb = 1'b0;
        end else if (m_lat != 0 && cyc + 1 == m_d + 2 * m_lat + 2) begin
          m_vv = 1'b1;
          m_iv = 1'b1;
        end
      end
      if (eos) begin
        if (m_busy) begin
          m_ovr = (m_ovr == 16'hFFFF) ? m_ovr : m_ovr + 16'd1;
        end else begin
          nb = 1'b1;
          m_d = cyc + 1;
          m_lat = lat;
          m_vexp = pk(v_raw);
          m_iexp = pk(i_raw);
        end
      end
      m_busy = nb;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int k;
    int v0;
    int i0;
    rst = 1'b1;
    eos = 1'b0;
    v_if.tready = 1'b1;
    i_if.tready = 1'b1;
    ticks(3);
    rst = 1'b0;
    tick();
    chk("reset_outputs", {den, v_if.tvalid, i_if.tvalid, v_if.tlast, err, daddr}, 32'd0);
    chk("reset_overrun", {16'd0, ovr}, 32'd0);

    // Scenario 1: nominal pair, 5-cycle latency
    v0 = v_hs; i0 = i_hs;
    eos = 1'b1; tick(); eos = 1'b0;
    k = 1;
    while (!(v_if.tvalid && i_if.tvalid) && k < 20) begin tick(); k++; end
    chk("s1_latency", k, 5);
    chk("s1_vdata", {16'd0, v_if.tdata}, 32'h1ABC);
    chk("s1_idata", {16'd0, i_if.tdata}, 32'h1123);
    chk("s1_tlast", {30'd0, v_if.tlast, i_if.tlast}, 32'h3);
    ticks(4);
    chk("s1_pairs", (v_hs - v0) * 16 + (i_hs - i0), 17);

    // Scenario 2: voltage stalled 10 cycles, current accepts at once
    v_if.tready = 1'b0;
    eos = 1'b1; tick(); eos = 1'b0;
    ticks(4);
    ticks(10);
    chk("s2_v_hold", {15'd0, v_if.tvalid, v_if.tdata}, 32'h11ABC);
    chk("s2_i_done", {31'd0, i_if.tvalid}, 32'd0);
    v_if.tready = 1'b1;
    tick();
    chk("s2_v_done", {31'd0, v_if.tvalid}, 32'd0);
    eos = 1'b1; tick(); eos = 1'b0;
    ticks(10);
    chk("s2_no_overrun", {16'd0, ovr}, 32'd0);

    // Scenario 3: DRP never answers, then a normal read recovers
    v0 = v_hs; i0 = i_hs;
    lat = 0;
    eos = 1'b1; tick(); eos = 1'b0;
    ticks(TMO);
    chk("s3_err_before", {31'd0, err}, 32'd0);
    tick();
    chk("s3_err_after", {31'd0, err}, 32'd1);
    ticks(5);
    chk("s3_no_valid", (v_hs - v0) + (i_hs - i0), 0);
    lat = 1; v_raw = 16'h5670; i_raw = 16'h9AB0;
    eos = 1'b1; tick(); eos = 1'b0;
    k = 1;
    while (!(v_if.tvalid && i_if.tvalid) && k < 20) begin tick(); k++; end
    chk("s3_recover_vdata", {16'd0, v_if.tdata}, 32'h1567);
    chk("s3_recover_idata", {16'd0, i_if.tdata}, 32'h19AB);
    ticks(4);
    chk("s3_err_sticky", {31'd0, err}, 32'd1);

    // Scenario 4: three eos pulses during a stalled push
    v0 = v_hs; i0 = i_hs;
    v_if.tready = 1'b0; i_if.tready = 1'b0;
    eos = 1'b1; tick(); eos = 1'b0;
    ticks(6);
    for (int p = 0; p < 3; p++) begin
      eos = 1'b1; tick(); eos = 1'b0; ticks(2);
    end
    chk("s4_overrun", {16'd0, ovr}, 32'd3);
    chk("s4_hold", {15'd0, v_if.tvalid, v_if.tdata}, 32'h11567);
    v_if.tready = 1'b1; i_if.tready = 1'b1;
    ticks(6);
    chk("s4_pairs", (v_hs - v0) * 16 + (i_hs - i0), 17);

    // Scenario 5: reset in WAIT_I with a late drdy afterwards
    v0 = v_hs; i0 = i_hs;
    lat = 3; v_raw = 16'hABC0; i_raw = 16'h1230;
    eos = 1'b1; tick(); eos = 1'b0;
    ticks(5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s5_reset_state", {den, v_if.tvalid, i_if.tvalid, err, ovr}, 32'd0);
    ticks(12);
    chk("s5_no_output", (v_hs - v0) + (i_hs - i0), 0);
    lat = 1;
    eos = 1'b1; tick(); eos = 1'b0;
    ticks(8);
    chk("s5_next_pair", (v_hs - v0) * 16 + (i_hs - i0), 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xadc_drp_sampler.md
XADC_DRP_SAMPLER -- requirements
Module: xadc_drp_sampler

Interface
REQ-001 SHALL have parameter VOLTAGE_ADDR, default 7'h13, meaning the DRP status-register address of the voltage channel (VAUX3).
REQ-002 SHALL have parameter CURRENT_ADDR, default 7'h1B, meaning the DRP status-register address of the current-monitor channel (VAUX11).
REQ-003 SHALL have parameter DRP_TIMEOUT, default 255, meaning the maximum number of cycles to wait for drdy.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port eos, input, 1 bit: XADC end-of-sequence pulse.
REQ-007 SHALL have port daddr, output, 7 bits: DRP address.
REQ-008 SHALL have port den, output, 1 bit: DRP enable.
REQ-009 SHALL have port dwe, output, 1 bit: DRP write enable, tied 0.
REQ-010 SHALL have port di, output, 16 bits: DRP write data, tied 0.
REQ-011 SHALL have port do_data, input, 16 bits: DRP read data.
REQ-012 SHALL have port drdy, input, 1 bit: DRP data ready.
REQ-013 SHALL have port voltage_channel, axis_interface.Source, 16 bits: voltage samples.
REQ-014 SHALL have port current_monitor_channel, axis_interface.Source, 16 bits: current samples.
REQ-015 SHALL have port overrun_count, output, 16 bits: saturating count of dropped eos pulses.
REQ-016 SHALL have port drp_timeout_err, output, 1 bit: sticky flag set when a DRP read times out.

Function
REQ-017 SHALL implement states IDLE -> REQ_V -> WAIT_V -> REQ_I -> WAIT_I -> PUSH -> IDLE.
REQ-018 IDLE: on eos=1, SHALL go to REQ_V the next cycle.
REQ-019 REQ_V/REQ_I: SHALL assert den for exactly one cycle with daddr = VOLTAGE_ADDR/CURRENT_ADDR, then enter WAIT_x.
REQ-020 WAIT_x: on drdy=1, SHALL capture sample = {XADC_PACKET_HEADER_LOW_SPEED_SAMPLE[3:0], do_data[15:4]}.
REQ-021 On eos=1 in any non-IDLE state, SHALL drop the pulse and increment overrun_count, saturating at 16'hFFFF.
REQ-022 WAIT_x: if the timeout counter reaches DRP_TIMEOUT without drdy, SHALL set drp_timeout_err, discard the partial pair, and return to IDLE; both streams stay idle.
REQ-023 SHALL ignore drdy outside WAIT_x.
REQ-024 PUSH: SHALL assert tvalid on both streams with tdata held stable, tlast=1, tkeep=1, tid=tuser=tdest=0.
REQ-025 In PUSH, each stream SHALL drop its tvalid the cycle after its own tvalid&tready, independent of the other stream.
REQ-026 SHALL leave PUSH for IDLE only after both handshakes complete; simultaneous handshakes in one cycle complete PUSH in one cycle.
REQ-027 Minimum latency from eos to both tvalid high SHALL be 5 cycles when drdy returns 1 cycle after den.
REQ-028 Under indefinite backpressure, SHALL hold PUSH with tdata stable; all eos pulses count as overruns.

Reset
REQ-029 On rst=1, SHALL force state=IDLE, den=0, daddr=0, both tvalid=0, tlast=0, overrun_count=0, drp_timeout_err=0, timeout counter=0.
REQ-030 Reset asserted mid-read or mid-PUSH SHALL abandon the transaction; no sample SHALL be emitted after reset deasserts until a new eos.
REQ-031 drdy arriving after reset for an abandoned read SHALL be ignored.

Structure
REQ-032 State enum xadc_sampler_state_t and the default channel addresses SHALL live in xadc_drp_package.
REQ-033 The header constant SHALL be taken from xadc_packet_package.
REQ-034 A sub-module xadc_drp_read (single read with timeout, reused for both channels) is permitted; there SHALL be no other sub-modules.

Verification
REQ-035 Scenario 1: eos pulse; drdy 1 cycle after each den; do_data=16'hABC0 (V) then 16'h1230 (I); tready=1 -> voltage tdata=16'h1ABC, current tdata=16'h1123, tlast=1, both tvalid 5 cycles after eos.
REQ-036 Scenario 2: voltage tready=0 for 10 cycles, current tready=1 -> current handshakes at once; voltage holds 16'h1ABC until tready rises; IDLE next cycle.
REQ-037 Scenario 3: drdy never asserted -> drp_timeout_err=1 after 255 wait cycles; no tvalid; next eos with normal drdy produces a valid pair.
REQ-038 Scenario 4: 3 eos pulses during a PUSH stalled by tready=0 -> overrun_count=3; exactly one sample pair is emitted.
REQ-039 Scenario 5: rst asserted in WAIT_I, then a late drdy after release -> den=0, tvalid=0, no output until the next eos.
